// File: rtl/siso_seq_pkg.sv
// rtl/siso_seq_pkg.sv - shared state type and default geometry for siso_seq_ctrl
// Purpose : FSM state enum and default WIDTH/DEPTH used by the serial sequencer.
// Contents: DEF_WIDTH, DEF_DEPTH, seq_state_t {IDLE, SHIFT, FLUSH}.
package siso_seq_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2
   } seq_state_t;

endpackage

// File: rtl/siso_chain.sv
// rtl/siso_chain.sv - DEPTH-stage serial delay chain with a valid tag per stage
// Purpose: shifts one data bit and one tag bit per cycle; tail feeds ser_out/ser_valid.
// Ports  : clk  - rising-edge clock
//          clr  - synchronous clear of every data and tag stage
//          din  - data bit entering stage 0
//          tin  - tag bit entering stage 0
//          dout - data bit at the tail stage
//          tout - tag bit at the tail stage
module siso_chain #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic din,
   input  logic tin,
   output logic dout,
   output logic tout
);

   logic [DEPTH-1:0] data_q;
   logic [DEPTH-1:0] tag_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         data_q <= '0;
         tag_q  <= '0;
      end else begin
         data_q[0] <= din;
         tag_q[0]  <= tin;
         for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
            tag_q[i]  <= tag_q[i-1];
         end
      end
   end

   assign dout = data_q[DEPTH-1];
   assign tout = tag_q[DEPTH-1];

endmodule

// File: rtl/siso_seq_ctrl.sv
// rtl/siso_seq_ctrl.sv - parallel-in serial-out sequencer with delay chain and abort
// Purpose: accepts a WIDTH-bit word, shifts it LSB first through a DEPTH-stage chain,
//          then flushes the chain with DEPTH idle bits before accepting the next word.
// Config : SISO_SEQ_CTRL_PARITY_EN appends an even-parity bit after the payload.
// Ports  : clk, rst (sync, active-high)
//          in_valid/in_ready/in_data - word handshake, taken only in IDLE
//          abort                     - cancels the word in progress
//          ser_out/ser_valid         - tail of the chain and its tag
//          done                      - pulse while the final bit is on ser_out
//          busy                      - FSM is not in IDLE
module siso_seq_ctrl
   import siso_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             done,
   output logic             busy
);

`ifdef SISO_SEQ_CTRL_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int BCNT_W = $clog2(WIDTH + 2);
   localparam int FCNT_W = $clog2(DEPTH + 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(N - 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(DEPTH - 1);

   seq_state_t        state;
   seq_state_t        next_state;
   logic [N-1:0]      shift_buf;
   logic [N-1:0]      load_word;
   logic [BCNT_W-1:0] bit_cnt;
   logic [FCNT_W-1:0] flush_cnt;
   logic              accept;
   logic              chain_din;
   logic              chain_tin;
   logic              chain_clr;
   logic              flush_last;

`ifdef SISO_SEQ_CTRL_PARITY_EN
   assign load_word = {^in_data, in_data};
`else
   assign load_word = in_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      chain_din  = 1'b0;
      chain_tin  = 1'b0;
      flush_last = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~abort;
            accept   = in_valid & ~abort;
            if (accept) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            chain_din = shift_buf[0];
            chain_tin = 1'b1;
            if (bit_cnt == BCNT_LAST) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            // The final bit reaches the tail in the last flush cycle.
            if (flush_cnt == FCNT_LAST) begin
               flush_last = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (abort) begin
         next_state = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         shift_buf <= '0;
         bit_cnt   <= '0;
         flush_cnt <= '0;
      end else if (accept) begin
         shift_buf <= load_word;
         bit_cnt   <= '0;
         flush_cnt <= '0;
      end else if (state == SHIFT) begin
         shift_buf <= shift_buf >> 1;
         bit_cnt   <= bit_cnt + 1'b1;
      end else if (state == FLUSH) begin
         flush_cnt <= flush_cnt + 1'b1;
      end
   end

   // Outside a word the chain only ever holds zeros, so clearing it on any
   // abort is harmless in IDLE and discards the word in SHIFT/FLUSH.
   assign chain_clr = rst | abort;

   siso_chain #(
      .DEPTH (DEPTH)
   ) u_chain (
      .clk  (clk),
      .clr  (chain_clr),
      .din  (chain_din),
      .tin  (chain_tin),
      .dout (ser_out),
      .tout (ser_valid)
   );

   assign done = flush_last & ~abort;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// tb/tb_siso_seq_ctrl.sv - self-checking bench for siso_seq_ctrl
module tb_siso_seq_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef SISO_SEQ_CTRL_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int MAXC = 4096;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             abort;
   logic             ser_out;
   logic             ser_valid;
   logic             done;
   logic             busy;

   always #5 clk = ~clk;

   siso_seq_ctrl #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .abort     (abort),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .done      (done),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit checking = 0;
   int free_at = 0;

   // Expected output timeline, indexed by absolute cycle number.
   logic exp_so   [MAXC];
   logic exp_sv   [MAXC];
   logic exp_done [MAXC];

   logic log_so   [MAXC];
   logic log_sv   [MAXC];
   logic log_done [MAXC];
   logic log_busy [MAXC];
   logic log_rdy  [MAXC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_future(input int c);
      for (int i = c + 1; i < c + DEPTH + N + 2 && i < MAXC; i++) begin
         exp_so[i]   = 1'b0;
         exp_sv[i]   = 1'b0;
         exp_done[i] = 1'b0;
      end
   endtask

   task automatic model_check();
      logic busy_e;
      busy_e = (cyc < free_at);
      chk($sformatf("busy@%0d", cyc), busy, busy_e);
      chk($sformatf("in_ready@%0d", cyc), in_ready, !busy_e && !abort);
      chk($sformatf("ser_out@%0d", cyc), ser_out, exp_so[cyc]);
      chk($sformatf("ser_valid@%0d", cyc), ser_valid, exp_sv[cyc]);
      chk($sformatf("done@%0d", cyc), done, exp_done[cyc] && !abort);
   endtask

   task automatic model_update();
      logic [31:0] word;
      if (rst) begin
         clear_future(cyc);
         free_at = cyc + 1;
      end else if (abort) begin
         if (cyc < free_at) begin
            clear_future(cyc);
            free_at = cyc + 1;
         end
      end else if (in_valid && cyc >= free_at) begin
         word = 32'(in_data);
`ifdef SISO_SEQ_CTRL_PARITY_EN
         word[WIDTH] = ^in_data;
`endif
         for (int k = 0; k < N; k++) begin
            exp_so[cyc + 1 + DEPTH + k] = word[k];
            exp_sv[cyc + 1 + DEPTH + k] = 1'b1;
         end
         exp_done[cyc + DEPTH + N] = 1'b1;
         free_at = cyc + DEPTH + N + 1;
      end
   endtask

   // One clock cycle: sample at the falling edge, then advance past the rising edge.
   task automatic cycle();
      @(negedge clk);
      log_so[cyc]   = ser_out;
      log_sv[cyc]   = ser_valid;
      log_done[cyc] = done;
      log_busy[cyc] = busy;
      log_rdy[cyc]  = in_ready;
      if (checking) model_check();
      model_update();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int t0;
      int t1;
      int cnt;
      logic a5_bits [8];
      a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      abort = 1'b0;
      for (int i = 0; i < MAXC; i++) begin
         exp_so[i] = 1'b0;
         exp_sv[i] = 1'b0;
         exp_done[i] = 1'b0;
      end
      @(posedge clk);
      #1;

      // Reset values
      run(2);
      rst = 1'b0;
      checking = 1;
      t0 = cyc;
      cycle();
      chk("rst_in_ready", log_rdy[t0], 1);
      chk("rst_ser_out", log_so[t0], 0);
      chk("rst_ser_valid", log_sv[t0], 0);
      chk("rst_done", log_done[t0], 0);
      chk("rst_busy", log_busy[t0], 0);

      // 0xA5, in_data scrambled while shifting
      t0 = cyc;
      in_valid = 1'b1;
      in_data = 8'hA5;
      cycle();
      in_valid = 1'b0;
      while (cyc < t0 + DEPTH + N + 3) begin
         in_data = WIDTH'($urandom);
         cycle();
      end
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("a5_bit%0d", k), log_so[t0 + 1 + DEPTH + k], a5_bits[k]);
         chk($sformatf("a5_valid%0d", k), log_sv[t0 + 1 + DEPTH + k], 1);
      end
      chk("a5_valid_before", log_sv[t0 + DEPTH], 0);
      chk("a5_done", log_done[t0 + DEPTH + N], 1);
      chk("a5_done_early", log_done[t0 + DEPTH + N - 1], 0);
      chk("a5_ready_after", log_rdy[t0 + DEPTH + N + 1], 1);
      chk("a5_busy_after", log_busy[t0 + DEPTH + N + 1], 0);
`ifdef SISO_SEQ_CTRL_PARITY_EN
      chk("a5_parity", log_so[t0 + 13], 0);
      chk("a5_parity_valid", log_sv[t0 + 13], 1);
      chk("a5_parity_done", log_done[t0 + 13], 1);

      t0 = cyc;
      in_valid = 1'b1;
      in_data = 8'h07;
      cycle();
      in_valid = 1'b0;
      run(DEPTH + N + 2);
      chk("x07_parity", log_so[t0 + 13], 1);
      chk("x07_done", log_done[t0 + 13], 1);
`endif

      // Abort in the middle of a word
      t0 = cyc;
      in_valid = 1'b1;
      in_data = WIDTH'($urandom);
      cycle();
      in_valid = 1'b0;
      while (cyc < t0 + 6) cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      run(DEPTH + N + 4);
      chk("abort_busy", log_busy[t0 + 7], 0);
      chk("abort_ser_valid", log_sv[t0 + 7], 0);
      chk("abort_ready", log_rdy[t0 + 7], 1);
      cnt = 0;
      for (int i = t0; i < t0 + DEPTH + N + 8; i++) cnt += int'(log_done[i]);
      chk("abort_no_done", cnt, 0);

      // Back-to-back words with in_valid held high
      t0 = cyc;
      t1 = t0 + DEPTH + N + 1;
      in_valid = 1'b1;
      in_data = 8'h01;
      cycle();
      in_data = 8'hFF;
      while (cyc <= t1) cycle();
      in_valid = 1'b0;
      run(DEPTH + N + 2);
      chk("b2b_busy_gap", log_busy[t1 - 1], 1);
      chk("b2b_ready", log_rdy[t1], 1);
      chk("b2b_busy_second", log_busy[t1 + 1], 1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("b2b_first_bit%0d", k), log_so[t0 + 1 + DEPTH + k], (k == 0) ? 1 : 0);
         chk($sformatf("b2b_second_bit%0d", k), log_so[t1 + 1 + DEPTH + k], 1);
         chk($sformatf("b2b_second_valid%0d", k), log_sv[t1 + 1 + DEPTH + k], 1);
      end

      // Reset in the middle of a word
      t0 = cyc;
      in_valid = 1'b1;
      in_data = WIDTH'($urandom);
      cycle();
      in_valid = 1'b0;
      run(2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      run(DEPTH + N + 3);
      chk("midrst_in_ready", log_rdy[t0 + 4], 1);
      chk("midrst_ser_out", log_so[t0 + 4], 0);
      chk("midrst_ser_valid", log_sv[t0 + 4], 0);
      chk("midrst_done", log_done[t0 + 4], 0);
      chk("midrst_busy", log_busy[t0 + 4], 0);
      cnt = 0;
      for (int i = t0 + 4; i < t0 + DEPTH + N + 6; i++) cnt += int'(log_sv[i]);
      chk("midrst_no_output", cnt, 0);

      // abort and in_valid together in IDLE
      t0 = cyc;
      in_valid = 1'b1;
      abort = 1'b1;
      cycle();
      in_valid = 1'b0;
      abort = 1'b0;
      cycle();
      chk("idle_abort_ready", log_rdy[t0], 0);
      chk("idle_abort_busy", log_busy[t0 + 1], 0);

      // Randomized traffic against the timeline model
      for (int i = 0; i < 1500; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = WIDTH'($urandom);
         abort    = ($urandom_range(0, 39) == 0);
         rst      = ($urandom_range(0, 199) == 0);
         cycle();
      end
      in_valid = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      run(DEPTH + N + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/siso_seq_ctrl.md
SISO_SEQ_CTRL -- requirements
Module: siso_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the parallel word width in bits; legal range 2..32.
REQ-002 Parameter DEPTH, default 4, is the number of flip-flop stages in the serial chain; legal range 1..16.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  a parallel word is offered on in_data.
REQ-006 in_ready  output  1  the block accepts a word this cycle.
REQ-007 in_data  input  WIDTH  parallel word, shifted out LSB first.
REQ-008 abort  input  1  synchronous cancel of the word in progress.
REQ-009 ser_out  output  1  tail of the serial chain.
REQ-010 ser_valid  output  1  ser_out carries a payload or parity bit this cycle.
REQ-011 done  output  1  one-cycle pulse marking the final bit of a word on ser_out.
REQ-012 busy  output  1  the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and FLUSH.
REQ-014 in_ready SHALL be 1 only in IDLE with abort low.
REQ-015 A handshake occurs when in_valid and in_ready are both 1; in_data SHALL then be captured into the shift buffer, the bit counter cleared and the FSM moved to SHIFT.
REQ-016 In SHIFT, the chain input SHALL be buf[0] with tag 1 each cycle; the buffer SHALL shift right and the counter increment; after N = WIDTH bits (N = WIDTH+1 with parity) the FSM SHALL move to FLUSH.
REQ-017 In FLUSH, the chain input SHALL be 0 with tag 0 for DEPTH cycles; the FSM SHALL then return to IDLE.
REQ-018 The chain SHALL carry a parallel valid tag per stage, and ser_valid SHALL equal the tail tag.
REQ-019 Latency: for a handshake in cycle T, payload bit k SHALL appear on ser_out in cycle T+1+DEPTH+k.
REQ-020 done SHALL be 1 exactly in cycle T+DEPTH+N, the cycle in which the last bit is on ser_out.
REQ-021 The FSM SHALL be in IDLE in cycle T+DEPTH+N+1, so back-to-back words are separated by a gap of exactly one cycle.
REQ-022 in_valid while busy SHALL be ignored and in_data SHALL not be sampled.
REQ-023 abort in SHIFT or FLUSH SHALL, on the next edge, move the FSM to IDLE, clear the buffer, clear every chain stage and tag, and suppress done.
REQ-024 abort and in_valid together in IDLE SHALL result in no capture; abort wins.
REQ-025 abort in IDLE with an empty chain SHALL have no effect.
REQ-026 Counters SHALL be $clog2(WIDTH+2) and $clog2(DEPTH+1) bits wide; neither counter may wrap within a word.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE and the buffer, counters, chain stages and tags SHALL all clear.
REQ-028 Outputs in the cycle after rst SHALL be in_ready=1, ser_out=0, ser_valid=0, done=0, busy=0.
REQ-029 rst SHALL override abort and any handshake, including reset mid-word.

Configuration
REQ-030 With SISO_SEQ_CTRL_PARITY_EN defined, an even-parity bit (XOR of in_data) SHALL follow the payload with tag 1, and N = WIDTH+1.
REQ-031 Without SISO_SEQ_CTRL_PARITY_EN, no parity logic SHALL exist and N = WIDTH.

Structure
REQ-032 Package siso_seq_pkg SHALL hold the state enum typedef (IDLE/SHIFT/FLUSH) and the default WIDTH and DEPTH constants.
REQ-033 Sub-module siso_chain (DEPTH data and tag stages, synchronous clear) SHALL be instantiated once.

Verification (WIDTH=8, DEPTH=4, handshake in cycle 0)
REQ-034 in_data=0xA5 -> ser_out 1,0,1,0,0,1,0,1 with ser_valid=1 in cycles 5..12; done in cycle 12; in_ready=1 in cycle 13.
REQ-035 With parity enabled, 0xA5 -> parity bit 0 in cycle 13; 0x07 -> parity bit 1 in cycle 13; done in cycle 13.
REQ-036 abort in cycle 6 -> busy=0 and ser_valid=0 in cycle 7; no done pulse.
REQ-037 in_valid held high with 0x01 then 0xFF -> second handshake in cycle 13; 0xFF bits on ser_out in cycles 18..25.
REQ-038 rst in cycle 3 -> all outputs at reset values in cycle 4; in_data changes during SHIFT do not alter ser_out.
